// File: rtl/rv_if_prefetch.sv
// Instruction-fetch front end: DEPTH-entry prefetch queue between a valid/ready imem and decode.
// Response-to-dec_valid is 1 cycle; issue stalls on full queue or redirect, stale responses are dropped.
module rv_if_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [XLEN-1:0]            dec_pc,
  output logic [31:0]                dec_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned CW = $clog2(2*DEPTH+1);
  localparam int unsigned OW = $clog2(DEPTH+1);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]    alloc_q, alloc_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [PW-1:0]    head_q, head_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic             run_q;
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];

  logic [PW-1:0] occ;
  logic [IW-1:0] alloc_idx, fill_idx, head_idx;
  logic          issue, pop, rsp_fill;

  assign alloc_idx = alloc_q[IW-1:0];
  assign fill_idx  = fill_q[IW-1:0];
  assign head_idx  = head_q[IW-1:0];
  assign occ       = alloc_q - head_q;
  assign occupancy = OW'(occ);

  // run_q holds issue off during the cycle in which reset is released
  assign imem_req_valid = run_q && !redirect_valid && (occ < PW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign dec_valid      = filled_q[head_idx] && !redirect_valid;
  assign dec_pc         = pc_q[head_idx];
  assign dec_instr      = instr_q[head_idx];

  assign issue    = imem_req_valid && imem_req_ready;
  assign pop      = dec_valid && dec_ready;
  assign rsp_fill = imem_rsp_valid && !redirect_valid && (drop_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    drop_d     = drop_q;
    filled_d   = filled_q;
    inflight_d = inflight_q + CW'(issue) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      // everything still outstanding after this cycle belongs to the old stream
      fetch_pc_d = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      filled_d   = '0;
      drop_d     = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (issue) begin
        fetch_pc_d          = fetch_pc_q + XLEN'(4);
        alloc_d             = alloc_q + PW'(1);
        filled_d[alloc_idx] = 1'b0;
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (rsp_fill) begin
        fill_d             = fill_q + PW'(1);
        filled_d[fill_idx] = 1'b1;
      end
      if (pop) begin
        head_d             = head_q + PW'(1);
        filled_d[head_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
      run_q      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      if (issue) begin
        pc_q[alloc_idx] <= fetch_pc_q;
      end
      if (rsp_fill) begin
        instr_q[fill_idx] <= imem_rsp_data;
      end
    end
  end

  a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (inflight_q != '0));
  a_fill_behind_alloc: assert property (@(posedge clk) disable iff (!rst_n)
    PW'(alloc_q - fill_q) <= PW'(DEPTH));

endmodule

// File: tb/tb_rv_if_prefetch.sv
// Bench for rv_if_prefetch: directed scenarios plus a long random run against a queue-level model.
module tb_rv_if_prefetch;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_instr;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  rv_if_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .occupancy(occupancy)
  );

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; bit filled; } ent_t;

  req_t        pend[$];   // imem: accepted, not yet answered
  ent_t        q[$];      // model: issued, not yet popped, current stream only
  int          stale;
  logic [31:0] m_fetch;
  bit          m_run;
  int          cyc = 0;
  int          lat_lo = 1, lat_hi = 1;
  int          n_pass = 0, n_total = 0;

  bit          obs_req_fire, obs_dec_fire, obs_dec_valid, obs_rsp;
  logic [31:0] obs_req_addr, obs_dec_pc;
  bit          obs_req_valid;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    pend.delete();
    q.delete();
    stale   = 0;
    m_fetch = RESET_PC;
    m_run   = 1'b0;
  endtask

  // One clock: called at a negedge with req_ready/dec_ready/redirect already set.
  task automatic cycle();
    bit   exp_req_v, exp_dec_v, done;
    ent_t e;
    int   lat;
    imem_rsp_valid = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? imem_word(pend[0].addr) : $urandom;
    #1;
    exp_req_v = m_run && !redirect_valid && (q.size() < DEPTH);
    exp_dec_v = !redirect_valid && (q.size() > 0) && q[0].filled;

    n_total++;
    if (imem_req_valid !== exp_req_v)
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req_v);
    else n_pass++;
    n_total++;
    if (occupancy !== 3'(q.size()))
      $display("FAIL occupancy cyc=%0d got=%0d exp=%0d", cyc, occupancy, q.size());
    else n_pass++;
    n_total++;
    if (dec_valid !== exp_dec_v)
      $display("FAIL dec_valid cyc=%0d got=%b exp=%b", cyc, dec_valid, exp_dec_v);
    else n_pass++;
    if (exp_req_v) begin
      n_total++;
      if (imem_req_addr !== m_fetch)
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch);
      else n_pass++;
    end
    if (exp_dec_v) begin
      n_total++;
      if (dec_pc !== q[0].pc || dec_instr !== imem_word(q[0].pc))
        $display("FAIL dec_data cyc=%0d got=%h/%h exp=%h/%h", cyc, dec_pc, dec_instr,
                 q[0].pc, imem_word(q[0].pc));
      else n_pass++;
    end

    obs_req_valid = imem_req_valid;
    obs_req_fire  = imem_req_valid && imem_req_ready;
    obs_req_addr  = imem_req_addr;
    obs_dec_valid = dec_valid;
    obs_dec_fire  = dec_valid && dec_ready;
    obs_dec_pc    = dec_pc;
    obs_rsp       = imem_rsp_valid;

    if (imem_rsp_valid) void'(pend.pop_front());
    if (redirect_valid) begin
      stale   = pend.size();
      q.delete();
      m_fetch = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (imem_rsp_valid) begin
        if (stale > 0) stale--;
        else begin
          done = 1'b0;
          for (int k = 0; k < q.size(); k++) begin
            if (!done && !q[k].filled) begin
              e = q[k]; e.filled = 1'b1; q[k] = e; done = 1'b1;
            end
          end
        end
      end
      if (exp_dec_v && dec_ready) void'(q.pop_front());
      if (exp_req_v && imem_req_ready) begin
        q.push_back('{m_fetch, 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
    end
    if (obs_req_fire) begin
      lat = int'($urandom_range(lat_hi, lat_lo));
      pend.push_back('{imem_req_addr, cyc + lat});
    end
    m_run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    lat_lo = 1; lat_hi = 2;
    imem_req_ready = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0;
    repeat (7) cycle();
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    n_total++;
    if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0 || occupancy !== 3'd0)
      $display("FAIL reset_outputs got req=%b dec=%b occ=%0d exp 0/0/0", imem_req_valid, dec_valid, occupancy);
    else n_pass++;
    n_total++;
    if (dec_pc !== 32'h0 || dec_instr !== 32'h0)
      $display("FAIL reset_dec_data got=%h/%h exp=0/0", dec_pc, dec_instr);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle();
    #1;
    n_total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC)
      $display("FAIL first_req got valid=%b addr=%h exp 1/%h", imem_req_valid, imem_req_addr, RESET_PC);
    else n_pass++;
    repeat (4) cycle();
  endtask

  task automatic test_stream();
    logic [31:0] pcs[$];
    int          at[$];
    do_reset();
    lat_lo = 1; lat_hi = 1;
    imem_req_ready = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (obs_dec_fire) begin pcs.push_back(obs_dec_pc); at.push_back(cyc); end
    end
    n_total++;
    if (pcs.size() < 8) $display("FAIL stream_count got=%0d exp>=8", pcs.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (pcs[i] !== 32'(i*4) || at[i] !== at[0] + i)
          $display("FAIL stream_pop%0d got pc=%h cyc=%0d exp pc=%h cyc=%0d", i, pcs[i], at[i], i*4, at[0]+i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_full();
    int          fires = 0;
    logic [31:0] pcs[$];
    logic [31:0] resume = 32'hDEAD_BEEF;
    bit          got_resume = 1'b0;
    do_reset();
    lat_lo = 1; lat_hi = 1;
    imem_req_ready = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_req_fire) fires++;
    end
    #1;
    n_total++;
    if (fires !== DEPTH || imem_req_valid !== 1'b0 || occupancy !== 3'(DEPTH))
      $display("FAIL full_stall got fires=%0d req=%b occ=%0d exp %0d/0/%0d", fires, imem_req_valid, occupancy, DEPTH, DEPTH);
    else n_pass++;
    dec_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (obs_dec_fire) pcs.push_back(obs_dec_pc);
      if (obs_req_fire && !got_resume) begin resume = obs_req_addr; got_resume = 1'b1; end
    end
    n_total++;
    if (pcs.size() < 4 || pcs[0] !== 32'h0 || pcs[1] !== 32'h4 || pcs[2] !== 32'h8 || pcs[3] !== 32'hC)
      $display("FAIL full_drain got %0d pops first=%h exp 0,4,8,C", pcs.size(), pcs.size() > 0 ? pcs[0] : 32'hX);
    else n_pass++;
    n_total++;
    if (resume !== 32'h10)
      $display("FAIL full_resume got=%h exp=00000010", resume);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] held[3];
    bit          vld[3];
    do_reset();
    lat_lo = 1; lat_hi = 1;
    imem_req_ready = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0;
    repeat (4) cycle();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      held[i] = obs_req_addr; vld[i] = obs_req_valid;
    end
    imem_req_ready = 1'b1;
    cycle();
    n_total++;
    if (!vld[0] || !vld[1] || !vld[2] || held[1] !== held[0] || held[2] !== held[0])
      $display("FAIL stall_hold got %h %h %h exp all equal and valid", held[0], held[1], held[2]);
    else n_pass++;
    n_total++;
    if (!obs_req_fire || obs_req_addr !== held[0] || held[0] !== 32'hC)
      $display("FAIL stall_release got fire=%b addr=%h exp 1/0000000c", obs_req_fire, obs_req_addr);
    else n_pass++;
  endtask

  task automatic test_redirect();
    logic [31:0] pcs[$];
    do_reset();
    lat_lo = 3; lat_hi = 3;
    imem_req_ready = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0;
    repeat (3) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (obs_dec_fire) pcs.push_back(obs_dec_pc);
    end
    n_total++;
    if (pcs.size() < 2 || pcs[0] !== 32'h100 || pcs[1] !== 32'h104)
      $display("FAIL redirect_seq got n=%0d first=%h exp 00000100,00000104", pcs.size(), pcs.size() > 0 ? pcs[0] : 32'hX);
    else n_pass++;
  endtask

  task automatic test_redirect_collide();
    logic [31:0] tgt, first;
    bit          found = 1'b0, got = 1'b0;
    do_reset();
    lat_lo = 2; lat_hi = 2;
    imem_req_ready = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0;
    repeat (8) cycle();
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc && q.size() > 0 && q[0].filled) found = 1'b1;
      else cycle();
    end
    n_total++;
    if (!found) $display("FAIL collide_setup got=none exp=rsp+pop cycle within 20");
    else n_pass++;
    tgt = {$urandom_range(1, 255), 20'h0, 4'h0} | 32'h6;
    redirect_valid = 1'b1; redirect_pc = tgt;
    cycle();
    redirect_valid = 1'b0;
    n_total++;
    if (obs_dec_valid !== 1'b0 || obs_req_valid !== 1'b0 || obs_rsp !== 1'b1)
      $display("FAIL collide_cycle got dec=%b req=%b rsp=%b exp 0/0/1", obs_dec_valid, obs_req_valid, obs_rsp);
    else n_pass++;
    first = 32'hX;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (obs_dec_fire && !got) begin first = obs_dec_pc; got = 1'b1; end
    end
    n_total++;
    if (first !== (tgt & 32'hFFFF_FFFC))
      $display("FAIL collide_first got=%h exp=%h", first, tgt & 32'hFFFF_FFFC);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = (i % 500 == 499) ? 32'hFFFF_FFF5 : $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    model_reset();
    test_stream();
    test_reset();
    test_full();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
